mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port main-memory controller between the instruction cache and the load/store unit's data cache. Accepts block-granular read and write requests from both caches with fixed instruction-cache priority. Serves one request at a time from an internal block-addressed memory array after a fixed access latency. Read data is returned as a one-cycle response pulse to the requester that issued the read.

## Interface
- `N_MAIN_MEM_BLOCKS`, 1024: number of blocks in the array; must be a power of two.
- `MEM_LATENCY`, 10: cycles from acceptance to completion; must be ≥1.
- `clk` in 1: the single clock.
- `rst_aL` in 1: reset. One clock; reset is synchronous and active-low.
- `init` in 1: test load; the array takes `init_main_mem` on this edge.
- `init_main_mem` in `block_data_t [N_MAIN_MEM_BLOCKS-1:0]`: test image.
- `icache_req_valid` in 1: instruction-cache request.
- `icache_req_block_addr` in `main_mem_block_addr_t`: read block address. Icache requests are reads only.
- `icache_req_ready` out 1: icache request accepted this cycle.
- `icache_resp_valid` out 1: one-cycle read-data pulse to the icache.
- `icache_resp_block_data` out `block_data_t`: read data to the icache.
- `dcache_req_valid` in 1: data-cache request.
- `dcache_req_type` in `req_type_t`: 0 = read, 1 = write.
- `dcache_req_block_addr` in `main_mem_block_addr_t`: request block address.
- `dcache_req_block_data` in `block_data_t`: write data.
- `dcache_req_ready` out 1: dcache request accepted this cycle.
- `dcache_resp_valid` out 1: one-cycle read-data pulse to the dcache.
- `dcache_resp_block_data` out `block_data_t`: read data to the dcache.

## Operation
- FSM states:
  - IDLE: ready for a new request.
  - BUSY: latency counter running.
  - DONE: completion cycle.
- IDLE:
  - `icache_req_ready` = 1.
  - `dcache_req_ready` = ~`icache_req_valid`.
  - Accept on valid&ready. Latch requester, type, block addr and write data. Counter ← `MEM_LATENCY`-1.
  - Go to DONE if the counter is loaded with 0, otherwise to BUSY.
- BUSY: counter decrements each cycle. At 1 → DONE.
- DONE:
  - Read: assert the latched requester's `*_resp_valid` with `array[idx]`.
  - Write: array[idx] ← latched data on this edge; no response pulse.
  - Go to IDLE.
- Both readies are 0 in BUSY and DONE; requesters hold valid until accepted.
- Array index is `block_addr[$clog2(N_MAIN_MEM_BLOCKS)-1:0]`; upper address bits are ignored, so addresses wrap.
- Read data is sampled in DONE. A write accepted earlier is therefore visible to every later read.
- Simultaneous icache and dcache valids in IDLE: the icache wins; the dcache waits, with no starvation bound.
- `rst_aL`=0 at any point, including mid-request:
  - FSM → IDLE, counter → 0, latched request dropped.
  - Any in-flight write is lost and no response is issued.
  - Array contents are retained.
- `init`=1: the array is loaded and the FSM is forced to IDLE. Reset takes priority for FSM state.
- `init`=1 together with a request valid: the request is not accepted; both readies are 0.

## Timing
- Reset values:
  - both `*_resp_valid` = 0.
  - both `*_resp_block_data` = 0; data outputs are 0 whenever their valid is 0.
  - `icache_req_ready` = 1.
  - `dcache_req_ready` = ~`icache_req_valid` (combinational from state IDLE).
- Request accepted in cycle T → DONE (response or write) in cycle T+`MEM_LATENCY`.
- Next acceptance no earlier than T+`MEM_LATENCY`+1.
- Throughput: one request per `MEM_LATENCY`+1 cycles.
- Readies are combinational from state and `icache_req_valid`. Response outputs are combinational from state plus array read.

## Structure
- `global_defs` package holds the shared types:
  - `req_type_t` (READ=0, WRITE=1).
  - `block_data_t` (64-bit).
  - `main_mem_block_addr_t`.
  - new `mem_ctrl_state_t` enum (IDLE, BUSY, DONE).
  - new `mem_requester_t` (ICACHE, DCACHE).
- Sub-module `main_mem_array`:
  - Storage only: combinational read, synchronous write, bulk init.
  - No reset of contents.

## Test plan
- Read, latency and data:
  - Stimulus: init block 5 = 64'hDEAD_BEEF_0123_4567; icache reads block 5 at T, `MEM_LATENCY`=10.
  - Required: `icache_resp_valid` only at T+10 with that data; `dcache_resp_valid` stays 0.
- Write then read:
  - Stimulus: dcache writes 64'h1111 to block 7; then dcache reads block 7.
  - Required: no response pulse for the write; the read returns 64'h1111 at acceptance+10.
- Arbitration:
  - Stimulus: icache and dcache both valid in IDLE.
  - Required: icache accepted and `dcache_req_ready`=0. The dcache is accepted at T+11 and responds at T+21.
- Address wrap:
  - Stimulus: write to block `N_MAIN_MEM_BLOCKS`+3.
  - Required: a read of block 3 returns the written data.
- Reset mid-request:
  - Stimulus: assert `rst_aL`=0 at T+4 of a dcache write.
  - Required: no response; block unchanged; ready is 1 the cycle after release.
- Minimum latency:
  - Stimulus: `MEM_LATENCY`=1, read accepted at T.
  - Required: response at T+1; next acceptance at T+2.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the main-memory controller and its caches.
package global_defs;

    typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;

    typedef logic [63:0] block_data_t;

    localparam int unsigned MAIN_MEM_BLOCK_ADDR_W = 32;
    typedef logic [MAIN_MEM_BLOCK_ADDR_W-1:0] main_mem_block_addr_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_ctrl_state_t;

    typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} mem_requester_t;

endpackage

// File: rtl/mem_ctrl_array.sv
// Block-addressed storage: combinational read, synchronous write, bulk init.
// Contents have no reset and survive controller resets.
module main_mem_array
    import global_defs::*;
#(
    parameter int unsigned N_MAIN_MEM_BLOCKS = 1024,
    parameter int unsigned IDX_W             = $clog2(N_MAIN_MEM_BLOCKS)
) (
    input  logic                                clk_i,
    input  logic                                init_i,
    input  block_data_t [N_MAIN_MEM_BLOCKS-1:0] init_data_i,
    input  logic                                we_i,
    input  logic [IDX_W-1:0]                    idx_i,
    input  block_data_t                         wdata_i,
    output block_data_t                         rdata_o
);

    block_data_t [N_MAIN_MEM_BLOCKS-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (init_i) begin
            mem_q <= init_data_i;
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_ctrl.sv
// Single-port main-memory controller serving icache reads and dcache
// reads/writes one at a time, icache first, with a fixed access latency.
module mem_ctrl
    import global_defs::*;
#(
    parameter int unsigned N_MAIN_MEM_BLOCKS = 1024,
    parameter int unsigned MEM_LATENCY       = 10
) (
    input  logic                                clk,
    input  logic                                rst_aL,
    input  logic                                init,
    input  block_data_t [N_MAIN_MEM_BLOCKS-1:0] init_main_mem,
    input  logic                                icache_req_valid,
    input  main_mem_block_addr_t                icache_req_block_addr,
    output logic                                icache_req_ready,
    output logic                                icache_resp_valid,
    output block_data_t                         icache_resp_block_data,
    input  logic                                dcache_req_valid,
    input  req_type_t                           dcache_req_type,
    input  main_mem_block_addr_t                dcache_req_block_addr,
    input  block_data_t                         dcache_req_block_data,
    output logic                                dcache_req_ready,
    output logic                                dcache_resp_valid,
    output block_data_t                         dcache_resp_block_data
);

    localparam int unsigned IDX_W = $clog2(N_MAIN_MEM_BLOCKS);
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LOAD = cnt_t'(MEM_LATENCY - 1);

    mem_ctrl_state_t   state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    mem_requester_t    who_q, who_d;
    req_type_t         type_q, type_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    block_data_t       wdata_q, wdata_d;
    logic              accept;
    logic              rsp_read;
    logic              mem_we;
    block_data_t       rdata;

    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{icache_req_block_addr[MAIN_MEM_BLOCK_ADDR_W-1:IDX_W],
                                dcache_req_block_addr[MAIN_MEM_BLOCK_ADDR_W-1:IDX_W]};

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            who_q   <= ICACHE;
            type_q  <= READ;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (init) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            who_q   <= ICACHE;
            type_q  <= READ;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            who_q   <= who_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        who_d            = who_q;
        type_d           = type_q;
        idx_d            = idx_q;
        wdata_d          = wdata_q;
        accept           = 1'b0;
        icache_req_ready = 1'b0;
        dcache_req_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (!init) begin
                    icache_req_ready = 1'b1;
                    dcache_req_ready = !icache_req_valid;
                end
                if (icache_req_valid && icache_req_ready) begin
                    accept  = 1'b1;
                    who_d   = ICACHE;
                    type_d  = READ;
                    idx_d   = icache_req_block_addr[IDX_W-1:0];
                    wdata_d = '0;
                end else if (dcache_req_valid && dcache_req_ready) begin
                    accept  = 1'b1;
                    who_d   = DCACHE;
                    type_d  = dcache_req_type;
                    idx_d   = dcache_req_block_addr[IDX_W-1:0];
                    wdata_d = dcache_req_block_data;
                end
                if (accept) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (CNT_LOAD == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - cnt_t'(1);
                if (cnt_q == cnt_t'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_read = (state_q == DONE) && (type_q == READ);
    // A reset landing on the completion edge discards the pending write.
    assign mem_we   = (state_q == DONE) && (type_q == WRITE) && rst_aL;

    assign icache_resp_valid      = rsp_read && (who_q == ICACHE);
    assign dcache_resp_valid      = rsp_read && (who_q == DCACHE);
    assign icache_resp_block_data = icache_resp_valid ? rdata : '0;
    assign dcache_resp_block_data = dcache_resp_valid ? rdata : '0;

    main_mem_array #(
        .N_MAIN_MEM_BLOCKS(N_MAIN_MEM_BLOCKS),
        .IDX_W            (IDX_W)
    ) u_array (
        .clk_i      (clk),
        .init_i     (init),
        .init_data_i(init_main_mem),
        .we_i       (mem_we),
        .idx_i      (idx_q),
        .wdata_i    (wdata_q),
        .rdata_o    (rdata)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a default-latency instance and a latency-1 instance.
module tb_mem_ctrl;
    import global_defs::*;

    localparam int unsigned NA = 1024;
    localparam int unsigned LA = 10;
    localparam int unsigned NB = 16;
    localparam int unsigned LB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_aL, init;
    block_data_t [NA-1:0] img_a;
    block_data_t [NB-1:0] img_b;

    logic a_iv, a_irdy, a_irv, a_dv, a_drdy, a_drv;
    main_mem_block_addr_t a_iaddr, a_daddr;
    req_type_t a_dtype;
    block_data_t a_ddata, a_irdata, a_drdata;

    logic b_iv, b_irdy, b_irv, b_dv, b_drdy, b_drv;
    main_mem_block_addr_t b_iaddr, b_daddr;
    req_type_t b_dtype;
    block_data_t b_ddata, b_irdata, b_drdata;

    mem_ctrl #(.N_MAIN_MEM_BLOCKS(NA), .MEM_LATENCY(LA)) dut_a (
        .clk(clk), .rst_aL(rst_aL), .init(init), .init_main_mem(img_a),
        .icache_req_valid(a_iv), .icache_req_block_addr(a_iaddr), .icache_req_ready(a_irdy),
        .icache_resp_valid(a_irv), .icache_resp_block_data(a_irdata),
        .dcache_req_valid(a_dv), .dcache_req_type(a_dtype), .dcache_req_block_addr(a_daddr),
        .dcache_req_block_data(a_ddata), .dcache_req_ready(a_drdy),
        .dcache_resp_valid(a_drv), .dcache_resp_block_data(a_drdata)
    );

    mem_ctrl #(.N_MAIN_MEM_BLOCKS(NB), .MEM_LATENCY(LB)) dut_b (
        .clk(clk), .rst_aL(rst_aL), .init(init), .init_main_mem(img_b),
        .icache_req_valid(b_iv), .icache_req_block_addr(b_iaddr), .icache_req_ready(b_irdy),
        .icache_resp_valid(b_irv), .icache_resp_block_data(b_irdata),
        .dcache_req_valid(b_dv), .dcache_req_type(b_dtype), .dcache_req_block_addr(b_daddr),
        .dcache_req_block_data(b_ddata), .dcache_req_ready(b_drdy),
        .dcache_resp_valid(b_drv), .dcache_resp_block_data(b_drdata)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned src;   // 0 = icache, 1 = dcache
        block_data_t data;
        int unsigned due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_irv || a_drv) begin
            if (a_irv && a_drv) begin
                check("a_both_resp", 1, 0);
            end else if (qa.size() == 0) begin
                check("a_unexpected_resp", 1, 0);
            end else begin
                e = qa.pop_front();
                check("a_resp_src", a_irv ? 64'd0 : 64'd1, 64'(e.src));
                check("a_resp_data", a_irv ? a_irdata : a_drdata, e.data);
                check("a_resp_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_irv || b_drv) begin
            if (b_irv && b_drv) begin
                check("b_both_resp", 1, 0);
            end else if (qb.size() == 0) begin
                check("b_unexpected_resp", 1, 0);
            end else begin
                e = qb.pop_front();
                check("b_resp_src", b_irv ? 64'd0 : 64'd1, 64'(e.src));
                check("b_resp_data", b_irv ? b_irdata : b_drdata, e.data);
                check("b_resp_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic a_req(input int unsigned src, input req_type_t t, input main_mem_block_addr_t addr,
                         input block_data_t wd, input block_data_t exp_rd, output int unsigned t_acc);
        bit ok;
        ok    = 1'b0;
        t_acc = 0;
        if (src == 0) begin
            a_iv = 1'b1; a_iaddr = addr;
        end else begin
            a_dv = 1'b1; a_dtype = t; a_daddr = addr; a_ddata = wd;
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if ((src == 0 && a_irdy) || (src == 1 && a_drdy)) begin
                ok    = 1'b1;
                t_acc = cyc;
                if (t == READ) qa.push_back('{src: src, data: exp_rd, due: cyc + LA});
            end
        end
        if (!ok) check("a_accept_timeout", 0, 1);
        @(posedge clk); #1;
        a_iv = 1'b0;
        a_dv = 1'b0;
    endtask

    task automatic a_wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (a_irdy) ok = 1'b1;
        end
        if (!ok) check("a_idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    int unsigned t0, t1;
    bit got;

    initial begin
        rst_aL = 1'b0; init = 1'b0;
        a_iv = 1'b0; a_iaddr = '0; a_dv = 1'b0; a_dtype = READ; a_daddr = '0; a_ddata = '0;
        b_iv = 1'b0; b_iaddr = '0; b_dv = 1'b0; b_dtype = READ; b_daddr = '0; b_ddata = '0;
        img_a = '0;
        img_b = '0;
        img_a[5] = 64'hDEAD_BEEF_0123_4567;
        img_a[3] = 64'h0303_0303_0303_0303;
        img_a[9] = 64'h9999_0000_A5A5_0009;
        img_b[2] = 64'hB2B2_0000_0000_0002;
        img_b[3] = 64'hB3B3_0000_0000_0003;

        // Reset values
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_icache_ready", 64'(a_irdy), 1);
        check("rst_dcache_ready", 64'(a_drdy), 1);
        check("rst_icache_resp_valid", 64'(a_irv), 0);
        check("rst_dcache_resp_valid", 64'(a_drv), 0);
        check("rst_icache_resp_data", a_irdata, 0);
        check("rst_dcache_resp_data", a_drdata, 0);
        a_iv = 1'b1;
        #1;
        check("rst_dcache_ready_vs_ivalid", 64'(a_drdy), 0);
        a_iv = 1'b0;

        // Init cycle with requests pending: nothing is accepted
        @(posedge clk); #1;
        rst_aL = 1'b1; init = 1'b1; a_iv = 1'b1; a_dv = 1'b1; b_iv = 1'b1;
        @(negedge clk);
        check("init_icache_ready", 64'(a_irdy), 0);
        check("init_dcache_ready", 64'(a_drdy), 0);
        @(posedge clk); #1;
        init = 1'b0; a_iv = 1'b0; a_dv = 1'b0; b_iv = 1'b0;

        // Read latency and data, both requesters
        a_req(0, READ, 32'd5, '0, 64'hDEAD_BEEF_0123_4567, t0);
        a_req(1, READ, 32'd5, '0, 64'hDEAD_BEEF_0123_4567, t0);

        // Write then read back
        a_req(1, WRITE, 32'd7, 64'h1111, '0, t0);
        a_req(1, READ, 32'd7, '0, 64'h1111, t0);

        // Arbitration
        a_wait_idle();
        a_iv = 1'b1; a_iaddr = 32'd5;
        a_dv = 1'b1; a_dtype = READ; a_daddr = 32'd7;
        @(negedge clk);
        check("arb_icache_ready", 64'(a_irdy), 1);
        check("arb_dcache_ready", 64'(a_drdy), 0);
        t0 = cyc;
        qa.push_back('{src: 0, data: 64'hDEAD_BEEF_0123_4567, due: t0 + LA});
        @(posedge clk); #1;
        a_iv = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (a_drdy) begin
                got = 1'b1;
                t1  = cyc;
                qa.push_back('{src: 1, data: 64'h1111, due: t1 + LA});
            end
        end
        check("arb_dcache_accept_cycle", got ? 64'(t1) : 64'hFFFF_FFFF, 64'(t0 + LA + 1));
        @(posedge clk); #1;
        a_dv = 1'b0;

        // Address wrap
        a_req(1, WRITE, main_mem_block_addr_t'(NA + 3), 64'h3333_CAFE_0000_0003, '0, t0);
        a_req(0, READ, 32'd3, '0, 64'h3333_CAFE_0000_0003, t0);

        // Reset in the middle of a write
        a_req(1, WRITE, 32'd9, 64'hBAD0_BAD0_BAD0_BAD0, '0, t0);
        repeat (3) @(posedge clk);
        #1;
        rst_aL = 1'b0;
        @(posedge clk); #1;
        rst_aL = 1'b1;
        @(negedge clk);
        check("post_rst_icache_ready", 64'(a_irdy), 1);
        check("post_rst_dcache_ready", 64'(a_drdy), 1);
        repeat (15) @(posedge clk);
        #1;
        a_req(0, READ, 32'd9, '0, 64'h9999_0000_A5A5_0009, t0);

        // Minimum latency on the second instance
        b_iv = 1'b1; b_iaddr = 32'd2;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b_irdy) begin
                got = 1'b1;
                t0  = cyc;
                qb.push_back('{src: 0, data: 64'hB2B2_0000_0000_0002, due: t0 + LB});
            end
        end
        if (!got) check("b_accept_timeout", 0, 1);
        @(posedge clk); #1;
        b_iaddr = 32'd3;
        @(negedge clk);
        check("minlat_ready_in_done", 64'(b_irdy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("minlat_ready_next", 64'(b_irdy), 1);
        check("minlat_next_accept_cycle", 64'(cyc), 64'(t0 + 2));
        if (b_irdy) qb.push_back('{src: 0, data: 64'hB3B3_0000_0000_0003, due: cyc + LB});
        @(posedge clk); #1;
        b_iv = 1'b0;

        // Drain scoreboards
        for (int i = 0; i < 100 && (qa.size() + qb.size()) != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(qa.size() + qb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
